// File: rtl/inst_issue_queue.sv
// Circular instruction queue between dual-word fetch and the dual decoders.
// Compacts up to two fetched words per cycle and presents the two oldest entries.
module inst_issue_queue #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned FULL_MARGIN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       stall,
    input  logic                       issue_i,
    input  logic                       issue_mode_i,
    input  logic [31:0]                inst1_i,
    input  logic [31:0]                inst2_i,
    input  logic [31:0]                inst1_addr_i,
    input  logic [31:0]                inst2_addr_i,
    input  logic                       inst1_valid_i,
    input  logic                       inst2_valid_i,
    output logic [31:0]                issue_inst1_o,
    output logic [31:0]                issue_inst2_o,
    output logic [31:0]                issue_inst1_addr_o,
    output logic [31:0]                issue_inst2_addr_o,
    output logic                       issue_inst1_valid_o,
    output logic                       issue_inst2_valid_o,
    output logic                       buffer_full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] head_q, tail_q, head_d, tail_d;
    logic [AW-1:0] head_nxt1, tail_nxt1;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [CW-1:0] free_slots, push_req, push_cnt, pop_want, pop_cnt;
    logic [63:0]   first_entry;

    assign head_nxt1 = head_q + AW'(1);
    assign tail_nxt1 = tail_q + AW'(1);

    // Space is judged on start-of-cycle occupancy; same-cycle pops never make room.
    always_comb begin
        free_slots  = CW'(DEPTH) - count_q;
        push_req    = CW'(inst1_valid_i) + CW'(inst2_valid_i);
        push_cnt    = (push_req > free_slots) ? free_slots : push_req;
        pop_want    = issue_mode_i ? CW'(2) : CW'(1);
        pop_cnt     = (stall || !issue_i) ? '0 :
                      ((pop_want > count_q) ? count_q : pop_want);
        first_entry = inst1_valid_i ? {inst1_addr_i, inst1_i} : {inst2_addr_i, inst2_i};

        head_d     = head_q + pop_cnt[AW-1:0];
        tail_d     = tail_q + push_cnt[AW-1:0];
        count_d    = count_q + push_cnt - pop_cnt;
        overflow_d = (push_req > free_slots);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (push_cnt >= CW'(1)) mem_q[tail_q]    <= first_entry;
            if (push_cnt == CW'(2)) mem_q[tail_nxt1] <= {inst2_addr_i, inst2_i};
        end
    end

    always_comb begin
        issue_inst1_valid_o = (count_q >= CW'(1));
        issue_inst2_valid_o = (count_q >= CW'(2));
        {issue_inst1_addr_o, issue_inst1_o} = issue_inst1_valid_o ? mem_q[head_q]    : 64'd0;
        {issue_inst2_addr_o, issue_inst2_o} = issue_inst2_valid_o ? mem_q[head_nxt1] : 64'd0;
        buffer_full_o = (CW'(DEPTH) - count_q) < CW'(FULL_MARGIN);
        count_o       = count_q;
        overflow_o    = overflow_q;
    end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Scoreboard bench: stimulus updates a queue-based reference model and posts expected
// outputs; an independent monitor compares the DUT against them every cycle.
module tb_inst_issue_queue;

    localparam int DEPTH       = 16;
    localparam int FULL_MARGIN = 4;

    logic        clk, rst, flush, stall, issue_i, issue_mode_i;
    logic [31:0] inst1_i, inst2_i, inst1_addr_i, inst2_addr_i;
    logic        inst1_valid_i, inst2_valid_i;
    logic [31:0] issue_inst1_o, issue_inst2_o, issue_inst1_addr_o, issue_inst2_addr_o;
    logic        issue_inst1_valid_o, issue_inst2_valid_o, buffer_full_o, overflow_o;
    logic [4:0]  count_o;

    inst_issue_queue #(.DEPTH(DEPTH), .FULL_MARGIN(FULL_MARGIN)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall), .issue_i(issue_i),
        .issue_mode_i(issue_mode_i), .inst1_i(inst1_i), .inst2_i(inst2_i),
        .inst1_addr_i(inst1_addr_i), .inst2_addr_i(inst2_addr_i),
        .inst1_valid_i(inst1_valid_i), .inst2_valid_i(inst2_valid_i),
        .issue_inst1_o(issue_inst1_o), .issue_inst2_o(issue_inst2_o),
        .issue_inst1_addr_o(issue_inst1_addr_o), .issue_inst2_addr_o(issue_inst2_addr_o),
        .issue_inst1_valid_o(issue_inst1_valid_o), .issue_inst2_valid_o(issue_inst2_valid_o),
        .buffer_full_o(buffer_full_o), .count_o(count_o), .overflow_o(overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v1, v2, full, ovf;
        logic [63:0] e1, e2;
        int          cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] mq[$];     // reference model: oldest entry at index 0, each {addr, inst}
    int          errors = 0;
    int          checks = 0;
    logic [31:0] pc = 32'h0000_1000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus, advance the model, post the expected post-edge view.
    task automatic step(input bit r, input bit f, input bit st, input bit is, input bit md,
                        input bit v1, input bit v2,
                        input logic [31:0] i1, input logic [31:0] a1,
                        input logic [31:0] i2, input logic [31:0] a2);
        logic [63:0] ins[$];
        int          p, free, want;
        bit          ovf;
        exp_t        e;
        rst = r; flush = f; stall = st; issue_i = is; issue_mode_i = md;
        inst1_valid_i = v1; inst2_valid_i = v2;
        inst1_i = i1; inst1_addr_i = a1; inst2_i = i2; inst2_addr_i = a2;
        ovf = 1'b0;
        if (r || f) begin
            mq.delete();
        end else begin
            want = md ? 2 : 1;
            p    = (!st && is) ? ((want < mq.size()) ? want : mq.size()) : 0;
            free = DEPTH - mq.size();
            if (v1) ins.push_back({a1, i1});
            if (v2) ins.push_back({a2, i2});
            ovf = (ins.size() > free);
            repeat (p) void'(mq.pop_front());
            for (int k = 0; k < ins.size() && k < free; k++) mq.push_back(ins[k]);
        end
        e.cnt  = mq.size();
        e.v1   = (e.cnt >= 1);
        e.v2   = (e.cnt >= 2);
        e.e1   = e.v1 ? mq[0] : 64'd0;
        e.e2   = e.v2 ? mq[1] : 64'd0;
        e.full = ((DEPTH - e.cnt) < FULL_MARGIN);
        e.ovf  = ovf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push2(input bit is, input bit md);
        step(0, 0, 0, is, md, 1, 1, $urandom, pc, $urandom, pc + 4);
        pc = pc + 8;
    endtask

    task automatic push1(input bit is, input bit md);
        step(0, 0, 0, is, md, 1, 0, $urandom, pc, 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        pc = pc + 4;
    endtask

    // Monitor: compare whatever the DUT presents against the oldest posted expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("valid1", 64'(issue_inst1_valid_o), 64'(e.v1));
                chk("valid2", 64'(issue_inst2_valid_o), 64'(e.v2));
                chk("entry1", {issue_inst1_addr_o, issue_inst1_o}, e.e1);
                chk("entry2", {issue_inst2_addr_o, issue_inst2_o}, e.e2);
                chk("full",   64'(buffer_full_o), 64'(e.full));
                chk("count",  64'(count_o), 64'(e.cnt));
                chk("overflow", 64'(overflow_o), 64'(e.ovf));
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Basic dual push then dual issue
        step(0, 0, 0, 0, 0, 1, 1, 32'h2401_0001, 32'hBFC0_0000, 32'h2402_0002, 32'hBFC0_0004);
        step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle();
        // Only inst2 valid is compacted into the oldest slot
        step(0, 0, 0, 0, 0, 0, 1, 32'hAAAA_0000, 32'h0000_0100, 32'h2403_0003, 32'h0000_0104);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Fill to 12, then single issue while pushing 2/cycle across the wrap
        repeat (6) push2(0, 0);
        repeat (10) push2(1, 0);
        repeat (10) step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        // Reach 15, push 2: one written, one dropped
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (7) push2(0, 0);
        push1(0, 0);
        push2(0, 0);
        idle();
        repeat (9) step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        // Stall freezes pops, pushes proceed; flush beats a same-cycle push
        push2(0, 0); push2(0, 0); push1(0, 0);
        step(0, 0, 1, 1, 1, 1, 1, 32'h1111_1111, pc, 32'h2222_2222, pc + 4);
        pc = pc + 8;
        step(0, 1, 0, 1, 1, 1, 1, 32'h3333_3333, pc, 32'h4444_4444, pc + 4);
        pc = pc + 8;
        idle();
        // Dual issue with a single entry, then with none
        push1(0, 0);
        step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        // Mid-stream reset
        push2(0, 0); push2(1, 0);
        step(1, 0, 0, 1, 1, 1, 1, 32'h5555_5555, pc, 32'h6666_6666, pc + 4);
        idle();
        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit r, f, st, is, md, v1, v2;
            r  = ($urandom_range(0, 149) == 0);
            f  = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 3) == 0);
            is = ($urandom_range(0, 1) == 1);
            md = ($urandom_range(0, 1) == 1);
            v1 = ($urandom_range(0, 3) != 0);
            v2 = ($urandom_range(0, 3) != 0);
            step(r, f, st, is, md, v1, v2, $urandom, pc, $urandom, pc + 4);
            pc = pc + 8;
        end
        idle();
        repeat (3) @(posedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
